hazard_forward_unit: RTL
========================

Name: hazard_forward_unit

Overview:
- Next-generation data-hazard unit for the pipelined RISC-V core.
- Generalises EX/MEM and MEM/WB operand forwarding to NUM_SRC source operands and parametrised register-address width.
- Adds load-use stall detection and a scoreboard for one multi-cycle functional unit (mul/div), with busy tracking, timeout detection and a saturating stall counter.
- Sits beside the ID and EX stages; drives the EX operand muxes and the PC / IF-ID hold plus ID/EX bubble.

Parameters:
- REG_AW, 5: register address width; register file has 2**REG_AW entries, entry 0 hardwired zero.
- NUM_SRC, 2: source operands per instruction.
- MC_TIMEOUT, 64: cycles the multi-cycle unit may stay busy before mc_timeout is raised.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs  in  NUM_SRC*REG_AW  source registers of the instruction in ID; operand i is in slice i.
- id_rs_used  in  NUM_SRC  per-operand "source actually read" flags.
- id_rd  in  REG_AW  destination of the ID instruction.
- id_regwrite  in  1  ID instruction writes id_rd.
- id_is_mc  in  1  ID instruction needs the multi-cycle unit.
- ex_rs  in  NUM_SRC*REG_AW  ID/EX source registers.
- ex_rd  in  REG_AW  ID/EX destination.
- ex_regwrite  in  1  ID/EX writes a register.
- ex_memread  in  1  ID/EX instruction is a load.
- ex_mc_start  in  1  ID/EX instruction issues to the multi-cycle unit this cycle.
- mem_rd  in  REG_AW  EX/MEM destination.
- mem_regwrite  in  1  EX/MEM writes a register.
- wb_rd  in  REG_AW  MEM/WB destination.
- wb_regwrite  in  1  MEM/WB writes a register.
- mc_done  in  1  multi-cycle unit writes its result this cycle.
- mc_rd  in  REG_AW  destination of that result.
- fwd_sel  out  NUM_SRC*2  per-operand EX mux select.
- stall_id  out  1  hold PC and IF/ID; insert a bubble into ID/EX.
- mc_busy  out  1  multi-cycle unit occupied.
- mc_timeout  out  1  sticky error flag.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset: pending scoreboard all 0, mc_busy 0, busy timer 0, mc_timeout 0, stall_cnt 0.
- Reset is asynchronous; it aborts any in-flight multi-cycle tracking.
- fwd_sel, combinational, evaluated independently per operand i:
  - 2'b10 if mem_regwrite && mem_rd != 0 && mem_rd == ex_rs[i].
  - Else 2'b01 if wb_regwrite && wb_rd != 0 && wb_rd == ex_rs[i].
  - Else 2'b00.
  - EX/MEM has strictly higher priority than MEM/WB for every operand; priority is identical across operands.
- Load-use hazard, combinational: ex_memread && ex_regwrite && ex_rd != 0 && ex_rd == id_rs[i] && id_rs_used[i], for any i.
- RAW scoreboard hazard: pending[id_rs[i]] && id_rs_used[i], for any i.
  - Stall holds through the cycle in which mc_done clears that entry, because the register file is written at the end of that cycle.
- WAW hazard: id_regwrite && id_rd != 0 && pending[id_rd].
- Structural hazard: id_is_mc && mc_busy && !mc_done. Back-to-back issue is allowed in the cycle of completion.
- stall_id is the OR of all four hazards. It has zero-cycle latency (combinational from inputs and state).
- Scoreboard update each edge:
  - mc_done clears pending[mc_rd].
  - ex_mc_start && ex_rd != 0 sets pending[ex_rd].
  - Same register in both: the set wins.
  - Entry 0 is never set.
- mc_busy next value:
  - 1 on ex_mc_start.
  - Else 0 on mc_done.
  - Else hold.
- Busy timer:
  - Cleared when mc_busy is 0 and on every ex_mc_start.
  - Otherwise increments while busy.
  - On reaching MC_TIMEOUT, sets mc_timeout. The flag is sticky until reset; the timer saturates at that value.
- ex_mc_start while mc_busy && !mc_done is a protocol violation. The set still applies and mc_busy stays 1.
- mc_done while not busy still clears pending[mc_rd] and holds mc_busy at 0.
- stall_cnt increments on each cycle with stall_id = 1 and saturates at all-ones.

Decomposition:
- Package hazard_pkg holds:
  - Select encodings FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - A helper function for the nonzero-match compare.
- One natural sub-module, hazard_src_cmp: per-operand combinational compare that produces fwd_sel and the load-use / RAW flags.
  - Instantiated NUM_SRC times in a generate loop.
- Scoreboard, busy timer and counters live in the top module.

Test Plan:
- Forward priority: ex_rs0 = 5; mem_rd = 5, mem_regwrite = 1; wb_rd = 5, wb_regwrite = 1 -> fwd_sel[1:0] = 10. Repeat with ex_rs1 = 5 -> fwd_sel[3:2] = 10. Repeat with mem_rd = 0 -> 01.
- x0 suppression: ex_rs0 = 0, mem_rd = 0, mem_regwrite = 1 -> fwd_sel = 00. ex_memread with ex_rd = 0 and id_rs0 = 0 -> stall_id = 0.
- Load-use: ex_memread = 1, ex_rd = 7, id_rs1 = 7, id_rs_used = 2'b10 -> stall_id = 1 for exactly that cycle. With id_rs_used = 2'b01 -> stall_id = 0.
- Scoreboard RAW:
  - Stimulus: ex_mc_start with ex_rd = 9; next cycle id_rs0 = 9, id_rs_used = 1; mc_done with mc_rd = 9 asserted 4 cycles later.
  - Response: stall_id = 1 from the cycle after issue through the mc_done cycle, 0 the following cycle; mc_busy falls one cycle after mc_done.
- Structural and WAW:
  - While busy with rd = 3: id_is_mc = 1 -> stall. id_regwrite with id_rd = 3 -> stall.
  - mc_done and ex_mc_start in the same cycle, both rd = 3 -> pending[3] stays 1 and mc_busy stays 1.
- Timeout, counter and reset:
  - Issue with no mc_done for 64 cycles -> mc_timeout = 1 and stays high.
  - Hold a hazard for 2**CNT_W + 5 cycles -> stall_cnt = all-ones.
  - Assert rst_n = 0 mid-busy -> all outputs 0 immediately.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings and compare helper for the hazard/forwarding unit
//
// Purpose : forwarding-mux select encodings and the "nonzero register match"
//           compare used by every per-operand comparator.
// Ports   : none (package).

package hazard_pkg;

    // EX operand mux select encodings
    localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_WB  = 2'b01;  // operand from MEM/WB result
    localparam logic [1:0] FWD_MEM = 2'b10;  // operand from EX/MEM result

    // Widest register address the compare helper accepts; callers zero-extend.
    localparam int HZ_MAX_AW = 16;

    // True when a writer targets a real register (not x0) equal to the reader.
    function automatic logic nz_match(
        input logic                 we,
        input logic [HZ_MAX_AW-1:0] wr_addr,
        input logic [HZ_MAX_AW-1:0] rd_addr
    );
        return we && (wr_addr != '0) && (wr_addr == rd_addr);
    endfunction

endpackage

// File: rtl/hazard_src_cmp.sv
// rtl/hazard_src_cmp.sv - per-operand forwarding select and load-use / RAW hazard compare
//
// Purpose : purely combinational compare for one source operand.
// Ports   : ex_rs          - ID/EX source register of this operand
//           id_rs          - ID source register of this operand
//           id_rs_used     - ID instruction really reads id_rs
//           mem_rd/_regwrite, wb_rd/_regwrite - later-stage writers
//           ex_rd/_regwrite, ex_memread       - ID/EX writer (load detection)
//           pending        - multi-cycle scoreboard, one bit per register
//           fwd_sel        - EX mux select for this operand
//           load_use       - ID operand depends on a load in EX
//           raw_hit        - ID operand waits on a multi-cycle result

import hazard_pkg::*;

module hazard_src_cmp #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0]      ex_rs,
    input  logic [REG_AW-1:0]      id_rs,
    input  logic                   id_rs_used,
    input  logic [REG_AW-1:0]      mem_rd,
    input  logic                   mem_regwrite,
    input  logic [REG_AW-1:0]      wb_rd,
    input  logic                   wb_regwrite,
    input  logic [REG_AW-1:0]      ex_rd,
    input  logic                   ex_regwrite,
    input  logic                   ex_memread,
    input  logic [2**REG_AW-1:0]   pending,
    output logic [1:0]             fwd_sel,
    output logic                   load_use,
    output logic                   raw_hit
);

    logic mem_hit;
    logic wb_hit;
    logic ex_hit;

    always_comb begin
        mem_hit = nz_match(mem_regwrite, HZ_MAX_AW'(mem_rd), HZ_MAX_AW'(ex_rs));
        wb_hit  = nz_match(wb_regwrite,  HZ_MAX_AW'(wb_rd),  HZ_MAX_AW'(ex_rs));
        ex_hit  = nz_match(ex_regwrite,  HZ_MAX_AW'(ex_rd),  HZ_MAX_AW'(id_rs));

        // The younger EX/MEM value always shadows the older MEM/WB value.
        if (mem_hit) begin
            fwd_sel = FWD_MEM;
        end else if (wb_hit) begin
            fwd_sel = FWD_WB;
        end else begin
            fwd_sel = FWD_RF;
        end

        load_use = ex_memread && ex_hit && id_rs_used;
        // pending[0] is never set, so x0 reads cannot raise a RAW stall.
        raw_hit  = pending[id_rs] && id_rs_used;
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - operand forwarding, load-use / multi-cycle hazard stall and scoreboard
//
// Purpose : drives the EX operand muxes, the PC / IF-ID hold plus ID/EX bubble,
//           and tracks one multi-cycle functional unit (busy, timeout, pending regs).
// Ports   : clk, rst_n (async, active low)
//           id_rs/id_rs_used/id_rd/id_regwrite/id_is_mc - instruction in ID
//           ex_rs/ex_rd/ex_regwrite/ex_memread/ex_mc_start - instruction in ID/EX
//           mem_rd/mem_regwrite, wb_rd/wb_regwrite - EX/MEM and MEM/WB writers
//           mc_done/mc_rd - multi-cycle unit writeback
//           fwd_sel   - NUM_SRC x 2-bit EX mux selects
//           stall_id  - hold PC/IF-ID and bubble ID/EX
//           mc_busy   - multi-cycle unit occupied
//           mc_timeout- sticky "unit busy too long" flag
//           stall_cnt - saturating count of stalled cycles

import hazard_pkg::*;

module hazard_forward_unit #(
    parameter int REG_AW     = 5,
    parameter int NUM_SRC    = 2,
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_regwrite,
    input  logic                      id_is_mc,
    input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0]         ex_rd,
    input  logic                      ex_regwrite,
    input  logic                      ex_memread,
    input  logic                      ex_mc_start,
    input  logic [REG_AW-1:0]         mem_rd,
    input  logic                      mem_regwrite,
    input  logic [REG_AW-1:0]         wb_rd,
    input  logic                      wb_regwrite,
    input  logic                      mc_done,
    input  logic [REG_AW-1:0]         mc_rd,
    output logic [NUM_SRC*2-1:0]      fwd_sel,
    output logic                      stall_id,
    output logic                      mc_busy,
    output logic                      mc_timeout,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam int NREG  = 2**REG_AW;
    localparam int TMR_W = $clog2(MC_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(MC_TIMEOUT);

    logic [NREG-1:0]    pending_q,    pending_d;
    logic               mc_busy_q,    mc_busy_d;
    logic [TMR_W-1:0]   busy_tmr_q,   busy_tmr_d;
    logic               mc_timeout_q, mc_timeout_d;
    logic [CNT_W-1:0]   stall_cnt_q,  stall_cnt_d;

    logic [NUM_SRC-1:0] load_use_v;
    logic [NUM_SRC-1:0] raw_v;
    logic               waw_hz;
    logic               struct_hz;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        hazard_src_cmp #(
            .REG_AW (REG_AW)
        ) u_cmp (
            .ex_rs        (ex_rs[i*REG_AW +: REG_AW]),
            .id_rs        (id_rs[i*REG_AW +: REG_AW]),
            .id_rs_used   (id_rs_used[i]),
            .mem_rd       (mem_rd),
            .mem_regwrite (mem_regwrite),
            .wb_rd        (wb_rd),
            .wb_regwrite  (wb_regwrite),
            .ex_rd        (ex_rd),
            .ex_regwrite  (ex_regwrite),
            .ex_memread   (ex_memread),
            .pending      (pending_q),
            .fwd_sel      (fwd_sel[i*2 +: 2]),
            .load_use     (load_use_v[i]),
            .raw_hit      (raw_v[i])
        );
    end

    // Hazard detection
    always_comb begin
        waw_hz    = id_regwrite && (id_rd != '0) && pending_q[id_rd];
        // A unit finishing this cycle can accept the next issue immediately.
        struct_hz = id_is_mc && mc_busy_q && !mc_done;
        stall_id  = (|load_use_v) || (|raw_v) || waw_hz || struct_hz;
    end

    // Scoreboard, busy tracking, timeout and stall counter next-state
    always_comb begin
        pending_d = pending_q;
        if (mc_done) begin
            pending_d[mc_rd] = 1'b0;
        end
        // Applied after the clear so a same-register reissue keeps the entry set.
        if (ex_mc_start && (ex_rd != '0)) begin
            pending_d[ex_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;

        if (ex_mc_start) begin
            mc_busy_d = 1'b1;
        end else if (mc_done) begin
            mc_busy_d = 1'b0;
        end else begin
            mc_busy_d = mc_busy_q;
        end

        if (ex_mc_start || !mc_busy_q) begin
            busy_tmr_d = '0;
        end else if (busy_tmr_q != TMR_MAX) begin
            busy_tmr_d = busy_tmr_q + 1'b1;
        end else begin
            busy_tmr_d = busy_tmr_q;
        end

        mc_timeout_d = mc_timeout_q || (busy_tmr_d == TMR_MAX);

        if (stall_id && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q    <= '0;
            mc_busy_q    <= 1'b0;
            busy_tmr_q   <= '0;
            mc_timeout_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            pending_q    <= pending_d;
            mc_busy_q    <= mc_busy_d;
            busy_tmr_q   <= busy_tmr_d;
            mc_timeout_q <= mc_timeout_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign mc_busy    = mc_busy_q;
    assign mc_timeout = mc_timeout_q;
    assign stall_cnt  = stall_cnt_q;

endmodule
